muldiv_unit: RTL

Iterative RV32M multiply/divide unit that sits beside the ALU and writes its results to the register file's write port. It takes operands from the register file read ports (rs1/rs2 data), computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and raises a one-cycle write-back strobe (en/addr/data) that drives the register file's `wen`/`waddr`/`wdata`. While it works, `busy` stalls the core's PC.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// 32 iterations each, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_op;
  logic        r_neg;
  logic [5:0]  r_cnt;
  logic [31:0] r_opd;
  logic [31:0] r_rem;
  logic [63:0] r_acc;

  logic        w_accept;
  logic        w_finish;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_fast;
  logic [31:0] w_fast_res;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc_next;
  logic [32:0] w_div_shift;
  logic        w_div_ok;
  logic [31:0] w_div_diff;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_prod_hi_neg;
  logic [31:0] w_mul_res;
  logic [31:0] w_div_mag;
  logic [31:0] w_div_res;
  logic [31:0] w_final;

  // Operand decode for the request presented in IDLE.
  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_neg_a    = w_a_signed && rs1_data[31];
  assign w_neg_b    = w_b_signed && rs2_data[31];
  assign w_a_mag    = w_neg_a ? (32'd0 - rs1_data) : rs1_data;
  assign w_b_mag    = w_neg_b ? (32'd0 - rs2_data) : rs2_data;
  assign w_div_zero = op[2] && (rs2_data == 32'd0);
  assign w_div_ovf  = op[2] && !op[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign w_fast     = w_div_zero || w_div_ovf;
  assign w_fast_res = w_div_zero ? (op[1] ? rs1_data : 32'hFFFF_FFFF)
                                 : (op[1] ? 32'd0 : 32'h8000_0000);

  // Multiply step: low half of r_acc holds the multiplier and shifts out LSB first.
  assign w_mul_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
  assign w_mul_acc_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: r_acc[31:0] holds dividend bits shifting out MSB first
  // while quotient bits shift in; w_div_shift is the 33-bit partial remainder.
  assign w_div_shift = {r_rem, r_acc[31]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_diff  = w_div_shift[31:0] - r_opd;
  assign w_rem_next  = w_div_ok ? w_div_diff : w_div_shift[31:0];
  assign w_quo_next  = {r_acc[30:0], w_div_ok};

  // High word of the negated 64-bit product: carry into the top only when the low word is zero.
  assign w_prod_hi_neg = ~w_mul_acc_next[63:32] + {31'd0, (w_mul_acc_next[31:0] == 32'd0)};
  assign w_mul_res     = (r_op[1:0] == 2'b00) ? w_mul_acc_next[31:0]
                       : (r_neg ? w_prod_hi_neg : w_mul_acc_next[63:32]);
  assign w_div_mag     = r_op[1] ? w_rem_next : w_quo_next;
  assign w_div_res     = r_neg ? (32'd0 - w_div_mag) : w_div_mag;
  assign w_final       = r_op[2] ? w_div_res : w_mul_res;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_accept     = 1'b1;
          w_state_next = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (!flush && (r_cnt == 6'd31)) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 3'd0;
      r_neg   <= 1'b0;
      r_cnt   <= 6'd0;
      r_opd   <= 32'd0;
      r_rem   <= 32'd0;
      r_acc   <= 64'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= 5'd0;
      wb_data <= '0;
    end else begin
      busy  <= (w_state_next != S_IDLE);
      done  <= (w_state_next == S_DONE);
      wb_en <= (w_state_next == S_DONE) && (w_accept ? (rd != 5'd0) : (wb_addr != 5'd0));

      if (w_accept) begin
        r_op    <= op;
        r_neg   <= (op[2] && op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
        r_cnt   <= 6'd0;
        r_opd   <= op[2] ? w_b_mag : w_a_mag;
        r_acc   <= {32'd0, (op[2] ? w_a_mag : w_b_mag)};
        r_rem   <= 32'd0;
        wb_addr <= rd;
        if (w_fast) begin
          wb_data <= w_fast_res;
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 6'd1;
        if (r_op[2]) begin
          r_rem <= w_rem_next;
          r_acc <= {r_acc[63:32], w_quo_next};
        end else begin
          r_acc <= w_mul_acc_next;
        end
        if (w_finish) begin
          wb_data <= w_final;
        end
      end
    end
  end

endmodule
